// File: rtl/m_ext_divider_if.sv
// Request/response bundle between the M-class operand mux and the RV32M divide unit.
interface m_ext_divider_if #(
  parameter int XLEN = 32
);
  logic            iSTART;
  logic [2:0]      iFUNCT3;
  logic [XLEN-1:0] iALU_IN1_M;
  logic [XLEN-1:0] iALU_IN2_M;
  logic            iFLUSH;
  logic            oBUSY;
  logic            oVALID;
  logic [XLEN-1:0] oALU_OUT_M;

  modport master (
    output iSTART, iFUNCT3, iALU_IN1_M, iALU_IN2_M, iFLUSH,
    input  oBUSY, oVALID, oALU_OUT_M
  );

  modport slave (
    input  iSTART, iFUNCT3, iALU_IN1_M, iALU_IN2_M, iFLUSH,
    output oBUSY, oVALID, oALU_OUT_M
  );
endinterface

// File: rtl/m_ext_divider.sv
// RV32M DIV/DIVU/REM/REMU: radix-2 restoring divider, one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved in a single cycle.
module m_ext_divider #(
  parameter int XLEN = 32
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  m_ext_divider_if.slave   bus
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;

  logic              start_ok;
  logic              signed_op;
  logic              ovf_case;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     step_rem;
  logic [XLEN-1:0]   step_quo;

  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic en);
    return (en && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v,
                                                  input logic en);
    return en ? -v : v;
  endfunction

  assign start_ok  = bus.iSTART && bus.iFUNCT3[2] && !bus.iFLUSH && (state_q != S_CALC);
  assign signed_op = ~bus.iFUNCT3[0];
  assign ovf_case  = signed_op && (bus.iALU_IN1_M == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.iALU_IN2_M == {XLEN{1'b1}});

  // Trial subtract is one bit wider so its sign bit decides the quotient bit.
  assign shifted  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign step_rem = trial[XLEN] ? shifted : trial;
  assign step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;

    case (state_q)
      S_CALC: begin
        if (bus.iFLUSH) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
            out_d   = is_rem_q ? cond_negate(step_rem[XLEN-1:0], neg_rem_q)
                               : cond_negate(step_quo, neg_quo_q);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start_ok) begin
          is_rem_d = bus.iFUNCT3[1];
          if (bus.iALU_IN2_M == '0) begin
            state_d = S_DONE;
            out_d   = bus.iFUNCT3[1] ? bus.iALU_IN1_M : {XLEN{1'b1}};
          end else if (ovf_case) begin
            state_d = S_DONE;
            out_d   = bus.iFUNCT3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          end else begin
            state_d   = S_CALC;
            cnt_d     = CNT_W'(XLEN);
            rem_d     = '0;
            quo_d     = magnitude(bus.iALU_IN1_M, signed_op);
            dvs_d     = magnitude(bus.iALU_IN2_M, signed_op);
            neg_quo_d = signed_op && (bus.iALU_IN1_M[XLEN-1] ^ bus.iALU_IN2_M[XLEN-1]);
            neg_rem_d = signed_op && bus.iALU_IN1_M[XLEN-1];
          end
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Working registers are only meaningful in CALC, so they carry no reset.
  always_ff @(posedge iCLK) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvs_q     <= dvs_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    is_rem_q  <= is_rem_d;
  end

  assign bus.oBUSY      = (state_q == S_CALC);
  assign bus.oVALID     = (state_q == S_DONE) && !bus.iFLUSH;
  assign bus.oALU_OUT_M = out_q;

endmodule

// File: tb/tb_m_ext_divider.sv
// Scoreboard bench for m_ext_divider: each issued op queues its expected result and
// completion cycle; the monitor pops and compares on every oVALID pulse.
module tb_m_ext_divider;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  m_ext_divider_if #(.XLEN(XLEN)) bus ();

  m_ext_divider #(.XLEN(XLEN)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f3[1] ? 32'd0 : 32'h8000_0000;
    if (!f3[0]) return f3[1] ? sa % sb : sa / sb;
    return f3[1] ? a % b : a / b;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.oVALID) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("result", bus.oALU_OUT_M, e.val);
        check_eq("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for a single cycle; optionally records its expectation.
  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit push);
    exp_t e;
    bus.iSTART     = 1'b1;
    bus.iFUNCT3    = f3;
    bus.iALU_IN1_M = a;
    bus.iALU_IN2_M = b;
    if (push) begin
      e.val = model(f3, a, b);
      e.cyc = cyc + (is_special(f3, a, b) ? 1 : 33);
      sb_q.push_back(e);
    end
    step();
    bus.iSTART = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check_eq("drain_queue_empty", sb_q.size(), 32'd0);
    step();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    bus.iSTART     = 1'b0;
    bus.iFUNCT3    = 3'b000;
    bus.iALU_IN1_M = '0;
    bus.iALU_IN2_M = '0;
    bus.iFLUSH     = 1'b0;
    repeat (3) step();
    check_eq("reset_busy", bus.oBUSY, 32'd0);
    check_eq("reset_valid", bus.oVALID, 32'd0);
    check_eq("reset_out", bus.oALU_OUT_M, 32'd0);
    rst_n = 1'b1;
    step();

    // DIVU 100/7 with busy window checks, then REMU
    drive_op(3'b101, 32'd100, 32'd7, 1'b1);
    check_eq("busy_first_cycle", bus.oBUSY, 32'd1);
    repeat (31) step();
    check_eq("busy_last_cycle", bus.oBUSY, 32'd1);
    step();
    check_eq("busy_done_cycle", bus.oBUSY, 32'd0);
    drain();
    check_eq("divu_100_7_const", bus.oALU_OUT_M, 32'd14);
    drive_op(3'b111, 32'd100, 32'd7, 1'b1);
    drain();
    check_eq("remu_100_7_const", bus.oALU_OUT_M, 32'd2);

    // Signed ops
    drive_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1);
    drain();
    check_eq("div_m7_2_const", bus.oALU_OUT_M, 32'hFFFF_FFFD);
    drive_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1);
    drain();
    check_eq("rem_m7_2_const", bus.oALU_OUT_M, 32'hFFFF_FFFF);
    drive_op(3'b110, 32'd7, 32'hFFFF_FFFE, 1'b1);
    drain();
    check_eq("rem_7_m2_const", bus.oALU_OUT_M, 32'd1);

    // Divide by zero resolves in one cycle without busy
    drive_op(3'b101, 32'd5, 32'd0, 1'b1);
    check_eq("divzero_no_busy", bus.oBUSY, 32'd0);
    drain();
    check_eq("divu_by_zero_const", bus.oALU_OUT_M, 32'hFFFF_FFFF);
    drive_op(3'b110, 32'hFFFF_FFF9, 32'd0, 1'b1);
    check_eq("remzero_no_busy", bus.oBUSY, 32'd0);
    drain();
    check_eq("rem_by_zero_const", bus.oALU_OUT_M, 32'hFFFF_FFF9);

    // Signed overflow
    drive_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();
    check_eq("div_overflow_const", bus.oALU_OUT_M, 32'h8000_0000);
    drive_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();
    check_eq("rem_overflow_const", bus.oALU_OUT_M, 32'd0);

    // Start while busy is ignored
    drive_op(3'b101, 32'd1000, 32'd3, 1'b1);
    repeat (9) step();
    drive_op(3'b101, 32'd77, 32'd5, 1'b0);
    drain();
    check_eq("ignored_start_result", bus.oALU_OUT_M, 32'd333);

    // Back-to-back: second start lands in the DONE cycle
    drive_op(3'b101, 32'd90, 32'd9, 1'b1);
    repeat (32) step();
    drive_op(3'b111, 32'd90, 32'd7, 1'b1);
    drain();

    // funct3[2]=0 request is ignored
    drive_op(3'b001, 32'd10, 32'd3, 1'b0);
    check_eq("non_div_funct3_busy", bus.oBUSY, 32'd0);
    repeat (3) step();

    // Asynchronous reset mid-CALC
    drive_op(3'b101, 32'd12345, 32'd11, 1'b1);
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", bus.oBUSY, 32'd0);
    check_eq("async_rst_valid", bus.oVALID, 32'd0);
    check_eq("async_rst_out", bus.oALU_OUT_M, 32'd0);
    sb_q.delete();
    step();
    #2 rst_n = 1'b1;
    repeat (40) step();

    // Flush mid-CALC keeps the previous result and emits no valid
    drive_op(3'b101, 32'd100, 32'd7, 1'b1);
    drain();
    drive_op(3'b101, 32'd999, 32'd4, 1'b0);
    repeat (4) step();
    bus.iFLUSH = 1'b1;
    step();
    bus.iFLUSH = 1'b0;
    check_eq("flush_busy", bus.oBUSY, 32'd0);
    repeat (40) step();
    check_eq("flush_out_retained", bus.oALU_OUT_M, 32'd14);

    // Randomised mix across all four ops
    for (int i = 0; i < 20; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 2 == 0) b = b >> $urandom_range(0, 28);
      drive_op(f3, a, b, 1'b1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
